// File: rtl/fifo_serial_pkg.sv
// ---------------------------------------------------------------------------
// fifo_serial_pkg
//
// Shared definitions for the FIFO-draining serial transmitter:
//   tx_state_t  - frame sequencer states (idle, start bit, data bits, stop bit)
//   cnt_width() - width of a counter that must hold values 0 .. n-1, never
//                 narrower than one bit so degenerate parameters
//                 (CLKS_PER_BIT=1, DATA_W=1) still give legal vectors.
// ---------------------------------------------------------------------------
package fifo_serial_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } tx_state_t;

    // max(1, $clog2(n))
    function automatic int cnt_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/serial_bit_timer.sv
// ---------------------------------------------------------------------------
// serial_bit_timer
//
// Baud counter for the serial transmitter. Counts clk cycles within one
// serial bit and wraps every CLKS_PER_BIT cycles, so consecutive bits of a
// frame follow each other with no gap.
//
// Ports:
//   clk           in   sole clock, rising edge
//   reset         in   asynchronous, active-low reset
//   clear_i       in   hold the count at zero (used while the line is idle so
//                      the first bit of a frame starts from a known phase)
//   bit_end_o     out  high in the last cycle of each bit
//   bit_pre_end_o out  high in the second-to-last cycle of each bit; lets the
//                      parent register an output that must coincide with the
//                      last cycle. Never asserted when CLKS_PER_BIT=1.
// ---------------------------------------------------------------------------
module serial_bit_timer
    import fifo_serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    output logic bit_end_o,
    output logic bit_pre_end_o
);

    localparam int            CW   = cnt_width(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] PRE  = CW'((CLKS_PER_BIT > 1) ? (CLKS_PER_BIT - 2) : 0);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear_i || (cnt == LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign bit_end_o     = (cnt == LAST);
    assign bit_pre_end_o = (CLKS_PER_BIT > 1) && (cnt == PRE);

endmodule

// File: rtl/fifo_serial_tx.sv
// ---------------------------------------------------------------------------
// fifo_serial_tx
//
// Reader-side companion to the parameterized FIFO. Pops one word whenever
// the line is idle and the FIFO is non-empty, then sends it as an
// asynchronous serial frame: one start bit (0), DATA_W data bits LSB first,
// one stop bit (1). Every bit is held CLKS_PER_BIT clk cycles.
//
// Parameters:
//   DATA_W        FIFO word / frame data width (>= 1)
//   CLKS_PER_BIT  clk cycles per serial bit (>= 1)
//
// Ports:
//   clk              in   sole clock, rising edge
//   reset            in   asynchronous, active-low reset
//   fifo_empty_i     in   FIFO empty flag
//   fifo_pop_data_i  in   FIFO head word, valid while fifo_empty_i=0
//   fifo_pop_o       out  one-cycle pop request (combinational, idle only)
//   tx_o             out  serial line, idles high (registered)
//   busy_o           out  frame in progress (registered)
//   frame_done_o     out  pulse in the last cycle of the stop bit (registered)
// ---------------------------------------------------------------------------
module fifo_serial_tx
    import fifo_serial_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fifo_empty_i,
    input  logic [DATA_W-1:0] fifo_pop_data_i,
    output logic              fifo_pop_o,
    output logic              tx_o,
    output logic              busy_o,
    output logic              frame_done_o
);

    localparam int            BW       = cnt_width(DATA_W);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    tx_state_t         state;
    logic [BW-1:0]     bit_cnt;
    logic [DATA_W-1:0] shift_reg;
    logic [DATA_W-1:0] shift_next;
    logic              timer_clear;
    logic              bit_end;
    logic              bit_pre_end;
    logic              done_next;

    // The baud counter is parked at zero while idle, so the start bit that
    // follows a pop always lasts exactly CLKS_PER_BIT cycles.
    assign timer_clear = (state == ST_IDLE);

    serial_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk           (clk),
        .reset         (reset),
        .clear_i       (timer_clear),
        .bit_end_o     (bit_end),
        .bit_pre_end_o (bit_pre_end)
    );

    // Zero-latency pop: the FIFO is drained in the same cycle it reports a
    // word, but only from idle, and never while reset is held.
    assign fifo_pop_o = (state == ST_IDLE) && !fifo_empty_i && reset;

    assign shift_next = shift_reg >> 1;

    // frame_done_o is registered, so it is armed one cycle ahead of the final
    // stop-bit cycle. With one clock per bit the stop bit is a single cycle,
    // so the arming point falls in the last data bit instead.
    always_comb begin
        done_next = 1'b0;
        if (CLKS_PER_BIT == 1) begin
            done_next = (state == ST_DATA) && (bit_cnt == LAST_BIT);
        end else begin
            done_next = (state == ST_STOP) && bit_pre_end;
        end
    end

    // Frame sequencer with registered line/status outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            bit_cnt      <= '0;
            tx_o         <= 1'b1;
            busy_o       <= 1'b0;
            frame_done_o <= 1'b0;
        end else begin
            frame_done_o <= done_next;
            unique case (state)
                ST_IDLE: begin
                    tx_o <= 1'b1;
                    if (fifo_pop_o) begin
                        bit_cnt <= '0;
                        tx_o    <= 1'b0;
                        busy_o  <= 1'b1;
                        state   <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        tx_o  <= shift_reg[0];
                        state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        if (bit_cnt == LAST_BIT) begin
                            tx_o  <= 1'b1;
                            state <= ST_STOP;
                        end else begin
                            // next bit comes from the post-shift LSB
                            tx_o    <= shift_next[0];
                            bit_cnt <= bit_cnt + BW'(1);
                        end
                    end
                end
                ST_STOP: begin
                    if (bit_end) begin
                        busy_o <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
                default: begin
                    tx_o   <= 1'b1;
                    busy_o <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

    // Data shift register: loaded on pop, shifted at the end of each data
    // bit. Its contents are meaningless outside a frame, so it has no reset.
    always_ff @(posedge clk) begin
        if (fifo_pop_o) begin
            shift_reg <= fifo_pop_data_i;
        end else if ((state == ST_DATA) && bit_end) begin
            shift_reg <= shift_next;
        end
    end

endmodule

// File: tb/tb_fifo_serial_tx.sv
// ---------------------------------------------------------------------------
// tb_fifo_serial_tx
//
// Directed bench for fifo_serial_tx. Two instances share clk/reset:
//   dut8 : DATA_W=8, CLKS_PER_BIT=4
//   dut1 : DATA_W=1, CLKS_PER_BIT=1
// Each has a small queue-based FIFO model. Cycle numbering: cyc advances at
// every rising edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_fifo_serial_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;

    logic       f8_empty;
    logic [7:0] f8_data;
    logic       pop8, tx8, busy8, done8;

    logic       f1_empty;
    logic [0:0] f1_data;
    logic       pop1, tx1, busy1, done1;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0] q8[$];
    logic       q1[$];
    int pops8 = 0, last_pop8 = -1;
    int pops1 = 0, last_pop1 = -1;

    fifo_serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4)) dut8 (
        .clk             (clk),
        .reset           (reset),
        .fifo_empty_i    (f8_empty),
        .fifo_pop_data_i (f8_data),
        .fifo_pop_o      (pop8),
        .tx_o            (tx8),
        .busy_o          (busy8),
        .frame_done_o    (done8)
    );

    fifo_serial_tx #(.DATA_W(1), .CLKS_PER_BIT(1)) dut1 (
        .clk             (clk),
        .reset           (reset),
        .fifo_empty_i    (f1_empty),
        .fifo_pop_data_i (f1_data),
        .fifo_pop_o      (pop1),
        .tx_o            (tx1),
        .busy_o          (busy1),
        .frame_done_o    (done1)
    );

    function automatic void refresh8();
        f8_empty = (q8.size() == 0);
        f8_data  = (q8.size() > 0) ? q8[0] : 8'h00;
    endfunction

    function automatic void refresh1();
        f1_empty = (q1.size() == 0);
        f1_data  = (q1.size() > 0) ? q1[0] : 1'b0;
    endfunction

    // Expected line level rel cycles after a pop (DATA_W=8, CLKS_PER_BIT=4)
    function automatic logic exp_tx8(input logic [7:0] w, input int rel);
        if (rel >= 1 && rel <= 4)  return 1'b0;
        if (rel >= 5 && rel <= 36) return w[(rel - 5) / 4];
        return 1'b1;
    endfunction

    // FIFO models: a pop seen at the edge removes the head just after it
    always @(posedge clk) begin : fifo_model
        bit p8, p1;
        p8 = pop8;
        p1 = pop1;
        if (p8) begin pops8++; last_pop8 = cyc; end
        if (p1) begin pops1++; last_pop1 = cyc; end
        cyc = cyc + 1;
        #1;
        if (p8 && q8.size() > 0) void'(q8.pop_front());
        if (p1 && q1.size() > 0) void'(q1.pop_front());
        refresh8();
        refresh1();
    end

    task automatic test_reset();
        int t0;
        q8.push_back(8'h3C); refresh8();
        q1.push_back(1'b1);  refresh1();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_checks++; if (tx8 !== 1'b1)   begin n_fail++; $display("FAIL reset_tx8 cyc %0d: got %b want 1", k, tx8); end
            n_checks++; if (busy8 !== 1'b0) begin n_fail++; $display("FAIL reset_busy8 cyc %0d: got %b want 0", k, busy8); end
            n_checks++; if (pop8 !== 1'b0)  begin n_fail++; $display("FAIL reset_pop8 cyc %0d: got %b want 0", k, pop8); end
            n_checks++; if (done8 !== 1'b0) begin n_fail++; $display("FAIL reset_done8 cyc %0d: got %b want 0", k, done8); end
            n_checks++; if (tx1 !== 1'b1)   begin n_fail++; $display("FAIL reset_tx1 cyc %0d: got %b want 1", k, tx1); end
            n_checks++; if (pop1 !== 1'b0)  begin n_fail++; $display("FAIL reset_pop1 cyc %0d: got %b want 0", k, pop1); end
            n_checks++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL reset_busy1 cyc %0d: got %b want 0", k, busy1); end
        end
        @(negedge clk);
        reset = 1'b1;
        t0 = cyc;
        #1;
        n_checks++; if (pop8 !== 1'b1) begin n_fail++; $display("FAIL release_pop8: got %b want 1", pop8); end
        n_checks++; if (pop1 !== 1'b1) begin n_fail++; $display("FAIL release_pop1: got %b want 1", pop1); end
        repeat (45) @(negedge clk);
        n_checks++; if (busy8 !== 1'b0)   begin n_fail++; $display("FAIL release_frame_end busy8: got %b want 0", busy8); end
        n_checks++; if (pops8 !== 1)      begin n_fail++; $display("FAIL release_pop_count: got %0d want 1", pops8); end
        n_checks++; if (last_pop8 !== t0) begin n_fail++; $display("FAIL release_pop_cycle: got %0d want %0d", last_pop8, t0); end
    endtask

    task automatic test_single(input logic [7:0] w);
        int t0, p0;
        logic [7:0] dec;
        @(negedge clk);
        p0 = pops8;
        q8.push_back(w); refresh8();
        t0 = cyc;
        #1;
        n_checks++; if (pop8 !== 1'b1) begin n_fail++; $display("FAIL single_pop_latency: got %b want 1", pop8); end
        dec = '0;
        for (int k = 1; k <= 41; k++) begin
            @(negedge clk);
            n_checks++; if (tx8 !== exp_tx8(w, k))  begin n_fail++; $display("FAIL single_tx T+%0d: got %b want %b", k, tx8, exp_tx8(w, k)); end
            n_checks++; if (done8 !== (k == 40))    begin n_fail++; $display("FAIL single_done T+%0d: got %b want %b", k, done8, (k == 40)); end
            n_checks++; if (busy8 !== (k <= 40))    begin n_fail++; $display("FAIL single_busy T+%0d: got %b want %b", k, busy8, (k <= 40)); end
            if (k >= 5 && k <= 36 && ((k - 5) % 4) == 2) dec[(k - 5) / 4] = tx8;
        end
        n_checks++; if (dec !== w)            begin n_fail++; $display("FAIL single_decode: got %h want %h", dec, w); end
        n_checks++; if ((pops8 - p0) !== 1)   begin n_fail++; $display("FAIL single_pop_count: got %0d want 1", pops8 - p0); end
        n_checks++; if (last_pop8 !== t0)     begin n_fail++; $display("FAIL single_pop_cycle: got %0d want %0d", last_pop8, t0); end
    endtask

    task automatic test_back_to_back();
        int t0, p0;
        logic [7:0] dec0, dec1;
        logic e;
        @(negedge clk);
        p0 = pops8;
        q8.push_back(8'h00); q8.push_back(8'hFF); refresh8();
        t0 = cyc;
        #1;
        n_checks++; if (pop8 !== 1'b1) begin n_fail++; $display("FAIL b2b_first_pop: got %b want 1", pop8); end
        dec0 = 8'hFF; dec1 = 8'h00;
        for (int k = 1; k <= 82; k++) begin
            @(negedge clk);
            e = (k <= 41) ? exp_tx8(8'h00, k) : exp_tx8(8'hFF, k - 41);
            n_checks++; if (tx8 !== e)                         begin n_fail++; $display("FAIL b2b_tx T+%0d: got %b want %b", k, tx8, e); end
            n_checks++; if (done8 !== (k == 40 || k == 81))    begin n_fail++; $display("FAIL b2b_done T+%0d: got %b want %b", k, done8, (k == 40 || k == 81)); end
            n_checks++; if (busy8 !== (k != 41 && k <= 81))    begin n_fail++; $display("FAIL b2b_busy T+%0d: got %b want %b", k, busy8, (k != 41 && k <= 81)); end
            n_checks++; if (pop8 !== (k == 41))                begin n_fail++; $display("FAIL b2b_pop T+%0d: got %b want %b", k, pop8, (k == 41)); end
            if (k >= 5 && k <= 36 && ((k - 5) % 4) == 2)   dec0[(k - 5) / 4]  = tx8;
            if (k >= 46 && k <= 77 && ((k - 46) % 4) == 2) dec1[(k - 46) / 4] = tx8;
        end
        n_checks++; if (dec0 !== 8'h00)           begin n_fail++; $display("FAIL b2b_decode0: got %h want 00", dec0); end
        n_checks++; if (dec1 !== 8'hFF)           begin n_fail++; $display("FAIL b2b_decode1: got %h want ff", dec1); end
        n_checks++; if ((pops8 - p0) !== 2)       begin n_fail++; $display("FAIL b2b_pop_count: got %0d want 2", pops8 - p0); end
        n_checks++; if (last_pop8 !== t0 + 41)    begin n_fail++; $display("FAIL b2b_pop_period: got %0d want %0d", last_pop8, t0 + 41); end
    endtask

    task automatic test_starvation();
        int t0, p0, bad;
        p0 = pops8;
        bad = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (pop8 !== 1'b0 || tx8 !== 1'b1 || busy8 !== 1'b0) bad++;
        end
        n_checks++; if (bad !== 0)           begin n_fail++; $display("FAIL starve_idle_cycles: got %0d bad cycles want 0", bad); end
        n_checks++; if (pops8 !== p0)        begin n_fail++; $display("FAIL starve_pop_count: got %0d want %0d", pops8, p0); end
        // a word arriving mid-frame waits for the next idle cycle
        @(negedge clk);
        p0 = pops8;
        q8.push_back(8'h3C); refresh8();
        t0 = cyc;
        repeat (10) @(negedge clk);
        q8.push_back(8'hC3); refresh8();
        #1;
        n_checks++; if (pop8 !== 1'b0)  begin n_fail++; $display("FAIL late_word_no_pop: got %b want 0", pop8); end
        n_checks++; if (busy8 !== 1'b1) begin n_fail++; $display("FAIL late_word_busy: got %b want 1", busy8); end
        repeat (31) @(negedge clk);
        n_checks++; if (pop8 !== 1'b1)  begin n_fail++; $display("FAIL late_word_pop_idle: got %b want 1", pop8); end
        n_checks++; if (tx8 !== 1'b1)   begin n_fail++; $display("FAIL late_word_idle_tx: got %b want 1", tx8); end
        @(negedge clk);
        n_checks++; if (last_pop8 !== t0 + 41) begin n_fail++; $display("FAIL late_word_pop_cycle: got %0d want %0d", last_pop8, t0 + 41); end
        n_checks++; if ((pops8 - p0) !== 2)    begin n_fail++; $display("FAIL late_word_pop_count: got %0d want 2", pops8 - p0); end
        n_checks++; if (tx8 !== 1'b0)          begin n_fail++; $display("FAIL late_word_start: got %b want 0", tx8); end
        repeat (42) @(negedge clk);
        n_checks++; if (busy8 !== 1'b0)        begin n_fail++; $display("FAIL late_word_finish: got %b want 0", busy8); end
    endtask

    task automatic test_reset_mid_frame();
        int t0, t1, p0;
        logic [7:0] dec;
        @(negedge clk);
        q8.push_back(8'hA5); refresh8();
        t0 = cyc;
        repeat (18) @(negedge clk);   // inside data bit 3 (T+17..T+20)
        n_checks++; if (tx8 !== 1'b0)  begin n_fail++; $display("FAIL midreset_bit3_before: got %b want 0", tx8); end
        reset = 1'b0;
        #1;
        n_checks++; if (tx8 !== 1'b1)  begin n_fail++; $display("FAIL midreset_tx: got %b want 1", tx8); end
        n_checks++; if (busy8 !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b want 0", busy8); end
        p0 = pops8;
        @(negedge clk);
        q8.push_back(8'h96); refresh8();
        #1;
        n_checks++; if (pop8 !== 1'b0) begin n_fail++; $display("FAIL midreset_pop_gated: got %b want 0", pop8); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        t1 = cyc;
        #1;
        n_checks++; if (pop8 !== 1'b1) begin n_fail++; $display("FAIL midreset_repop: got %b want 1", pop8); end
        dec = '0;
        for (int k = 1; k <= 41; k++) begin
            @(negedge clk);
            n_checks++; if (tx8 !== exp_tx8(8'h96, k)) begin n_fail++; $display("FAIL midreset_tx T+%0d: got %b want %b", k, tx8, exp_tx8(8'h96, k)); end
            n_checks++; if (done8 !== (k == 40))       begin n_fail++; $display("FAIL midreset_done T+%0d: got %b want %b", k, done8, (k == 40)); end
            if (k >= 5 && k <= 36 && ((k - 5) % 4) == 2) dec[(k - 5) / 4] = tx8;
        end
        n_checks++; if (dec !== 8'h96)       begin n_fail++; $display("FAIL midreset_decode: got %h want 96", dec); end
        n_checks++; if ((pops8 - p0) !== 1)  begin n_fail++; $display("FAIL midreset_pop_count: got %0d want 1", pops8 - p0); end
        n_checks++; if (last_pop8 !== t1)    begin n_fail++; $display("FAIL midreset_pop_cycle: got %0d want %0d", last_pop8, t1); end
        n_checks++; if (t0 < 0)              begin n_fail++; $display("FAIL midreset_t0: got %0d", t0); end
    endtask

    task automatic test_corner_w1_c1();
        int t0, p0;
        logic exp_tx [1:8];
        exp_tx = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        @(negedge clk);
        p0 = pops1;
        q1.push_back(1'b1); q1.push_back(1'b0); refresh1();
        t0 = cyc;
        #1;
        n_checks++; if (pop1 !== 1'b1) begin n_fail++; $display("FAIL corner_pop: got %b want 1", pop1); end
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            n_checks++; if (tx1 !== exp_tx[k])           begin n_fail++; $display("FAIL corner_tx T+%0d: got %b want %b", k, tx1, exp_tx[k]); end
            n_checks++; if (done1 !== (k == 3 || k == 7)) begin n_fail++; $display("FAIL corner_done T+%0d: got %b want %b", k, done1, (k == 3 || k == 7)); end
            n_checks++; if (pop1 !== (k == 4))           begin n_fail++; $display("FAIL corner_pop T+%0d: got %b want %b", k, pop1, (k == 4)); end
            n_checks++; if (busy1 !== (k != 4 && k <= 7)) begin n_fail++; $display("FAIL corner_busy T+%0d: got %b want %b", k, busy1, (k != 4 && k <= 7)); end
        end
        n_checks++; if (last_pop1 !== t0 + 4) begin n_fail++; $display("FAIL corner_pop_period: got %0d want %0d", last_pop1, t0 + 4); end
        n_checks++; if ((pops1 - p0) !== 2)   begin n_fail++; $display("FAIL corner_pop_count: got %0d want 2", pops1 - p0); end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        refresh8();
        refresh1();
        test_reset();
        repeat (3) @(negedge clk);
        test_single(8'hA5);
        repeat (3) @(negedge clk);
        test_back_to_back();
        repeat (3) @(negedge clk);
        test_starvation();
        repeat (3) @(negedge clk);
        test_reset_mid_frame();
        repeat (3) @(negedge clk);
        test_corner_w1_c1();
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
